// File: rtl/alarm_ctrl_if.sv
// Front-panel signal bundle for the alarm clock controller: keypad and button
// strobes, the running time from the time counter, and everything the
// controller drives back to the time counter, display and buzzer.
interface alarm_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        time_btn;
    logic        alarm_btn;
    logic [15:0] time_data;
    logic [15:0] set_data;
    logic        load_time;
    logic [15:0] alarm_data;
    logic        alarm_en;
    logic [15:0] display_data;
    logic        entry_mode;
    logic        error;
    logic        buzzer;

    // Panel / time-counter side: drives keys, buttons and the running time.
    modport master (
        output key_valid, key_code, time_btn, alarm_btn, time_data,
        input  set_data, load_time, alarm_data, alarm_en,
               display_data, entry_mode, error, buzzer
    );

    // Controller side.
    modport slave (
        input  key_valid, key_code, time_btn, alarm_btn, time_data,
        output set_data, load_time, alarm_data, alarm_en,
               display_data, entry_mode, error, buzzer
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock front-panel controller: collects BCD HH:MM from the keypad,
// validates it, loads it as the time or stores it as the alarm, selects the
// display source, and rings the buzzer when the running time reaches the alarm.
module alarm_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alarm_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        SHOW_TIME  = 2'd0,
        KEY_ENTRY  = 2'd1,
        LOAD       = 2'd2,
        SHOW_ALARM = 2'd3
    } state_t;

    state_t          state;
    logic [15:0]     key_buf;
    logic [2:0]      digit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [15:0]     prev_time;
    logic            alarm_btn_d;

    logic is_digit;
    logic alarm_rise;
    logic clear_evt;
    logic time_changed;
    logic ring;
    logic entry_ok;

    assign is_digit     = bus.key_valid && (bus.key_code <= 4'd9);
    assign alarm_rise   = bus.alarm_btn && !alarm_btn_d;
    assign clear_evt    = bus.buzzer && (bus.key_valid || bus.time_btn || alarm_rise);
    assign time_changed = (bus.time_data != prev_time);
    assign ring         = bus.alarm_en && time_changed && (bus.time_data == bus.alarm_data);

    // Entry is a legal HH:MM only with four BCD digits, HH <= 23 and MM <= 59.
    assign entry_ok = (digit_cnt == 3'd4)
                   && (key_buf[15:12] <= 4'd2)
                   && (key_buf[11:8]  <= 4'd9)
                   && (key_buf[7:4]   <= 4'd5)
                   && (key_buf[3:0]   <= 4'd9)
                   && !((key_buf[15:12] == 4'd2) && (key_buf[11:8] > 4'd3));

    // Panel state machine, alarm compare and buzzer, all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= SHOW_TIME;
            key_buf        <= '0;
            digit_cnt      <= '0;
            to_cnt         <= '0;
            prev_time      <= '0;
            alarm_btn_d    <= 1'b0;
            bus.set_data   <= '0;
            bus.load_time  <= 1'b0;
            bus.alarm_data <= '0;
            bus.alarm_en   <= 1'b0;
            bus.entry_mode <= 1'b0;
            bus.error      <= 1'b0;
            bus.buzzer     <= 1'b0;
        end else begin
            bus.load_time <= 1'b0;
            bus.error     <= 1'b0;
            alarm_btn_d   <= bus.alarm_btn;
            prev_time     <= bus.time_data;

            // A clear event beats a simultaneous ring; a ring lasts until
            // the next change of time_data at most.
            if (clear_evt)
                bus.buzzer <= 1'b0;
            else if (ring)
                bus.buzzer <= 1'b1;
            else if (time_changed)
                bus.buzzer <= 1'b0;

            // LOAD always completes; elsewhere a buzzer-clearing event is
            // swallowed so it cannot also start or commit an entry.
            if (state == LOAD) begin
                state <= SHOW_TIME;
            end else if (!clear_evt) begin
                case (state)
                    SHOW_TIME: begin
                        if (is_digit) begin
                            key_buf        <= {12'h000, bus.key_code};
                            digit_cnt      <= 3'd1;
                            to_cnt         <= '0;
                            bus.entry_mode <= 1'b1;
                            state          <= KEY_ENTRY;
                        end else if (bus.alarm_btn) begin
                            state <= SHOW_ALARM;
                        end
                    end
                    KEY_ENTRY: begin
                        if (bus.time_btn || alarm_rise) begin
                            bus.entry_mode <= 1'b0;
                            to_cnt         <= '0;
                            if (!entry_ok) begin
                                bus.error <= 1'b1;
                                key_buf   <= '0;
                                digit_cnt <= '0;
                                state     <= SHOW_TIME;
                            end else if (bus.time_btn) begin
                                bus.set_data  <= key_buf;
                                bus.load_time <= 1'b1;
                                state         <= LOAD;
                            end else begin
                                bus.alarm_data <= key_buf;
                                bus.alarm_en   <= 1'b1;
                                state          <= SHOW_TIME;
                            end
                        end else if (is_digit) begin
                            key_buf <= {key_buf[11:0], bus.key_code};
                            if (digit_cnt != 3'd4)
                                digit_cnt <= digit_cnt + 3'd1;
                            to_cnt <= '0;
                        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            to_cnt         <= '0;
                            bus.entry_mode <= 1'b0;
                            state          <= SHOW_TIME;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    SHOW_ALARM: begin
                        if (!bus.alarm_btn)
                            state <= SHOW_TIME;
                    end
                    default: state <= SHOW_TIME;
                endcase
            end
        end
    end

    // Display source follows the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.display_data <= '0;
        end else begin
            case (state)
                KEY_ENTRY:  bus.display_data <= key_buf;
                SHOW_ALARM: bus.display_data <= bus.alarm_data;
                default:    bus.display_data <= bus.time_data;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with hand-computed expectations.
module tb_alarm_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alarm_ctrl_if bus();

    alarm_ctrl #(
        .TIMEOUT_CYCLES(16),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    task automatic commit_time();
        bus.time_btn = 1'b1;
        tick();
        bus.time_btn = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.time_btn  = 1'b0;
        bus.alarm_btn = 1'b0;
        bus.time_data = 16'h0900;
        #1;
        tick();
        tick();
        check("rst_set_data",   bus.set_data, 16'h0000);
        check("rst_load_time",  16'(bus.load_time), 16'h0);
        check("rst_alarm_en",   16'(bus.alarm_en), 16'h0);
        check("rst_buzzer",     16'(bus.buzzer), 16'h0);
        check("rst_entry_mode", 16'(bus.entry_mode), 16'h0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_display", bus.display_data, 16'h0900);

        // valid time entry 12:30
        press(4'd1);
        press(4'd2);
        check("entry_mode_on", 16'(bus.entry_mode), 16'h1);
        press(4'd3);
        press(4'd0);
        commit_time();
        check("t1_set_data", bus.set_data, 16'h1230);
        check("t1_load_hi",  16'(bus.load_time), 16'h1);
        tick();
        check("t1_load_lo",  16'(bus.load_time), 16'h0);
        tick();
        check("t1_display",  bus.display_data, 16'h0900);

        // invalid entries: hour 24, minute 60, three digits
        enter4(4'd2, 4'd4, 4'd0, 4'd0);
        commit_time();
        check("e24_error", 16'(bus.error), 16'h1);
        check("e24_noload", 16'(bus.load_time), 16'h0);
        tick();
        check("e24_err_lo", 16'(bus.error), 16'h0);
        check("e24_noload2", 16'(bus.load_time), 16'h0);
        check("e24_set_kept", bus.set_data, 16'h1230);
        enter4(4'd1, 4'd2, 4'd6, 4'd0);
        commit_time();
        check("e60_error", 16'(bus.error), 16'h1);
        tick();
        check("e60_noload", 16'(bus.load_time), 16'h0);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        commit_time();
        check("e3d_error", 16'(bus.error), 16'h1);
        tick();
        check("e3d_noload", 16'(bus.load_time), 16'h0);

        // alarm entry 07:30 by alarm_btn rise, then hold to show it
        enter4(4'd0, 4'd7, 4'd3, 4'd0);
        bus.alarm_btn = 1'b1;
        tick();
        check("a1_alarm_data", bus.alarm_data, 16'h0730);
        check("a1_alarm_en",   16'(bus.alarm_en), 16'h1);
        check("a1_no_load",    16'(bus.load_time), 16'h0);
        tick();
        tick();
        tick();
        check("a1_show_alarm", bus.display_data, 16'h0730);
        bus.alarm_btn = 1'b0;
        tick();
        tick();
        check("a1_show_time",  bus.display_data, 16'h0900);

        // alarm 07:31, time steps 07:30 -> 07:31
        enter4(4'd0, 4'd7, 4'd3, 4'd1);
        bus.alarm_btn = 1'b1;
        tick();
        bus.alarm_btn = 1'b0;
        check("a2_alarm_data", bus.alarm_data, 16'h0731);
        bus.time_data = 16'h0730;
        tick();
        tick();
        check("ring_before", 16'(bus.buzzer), 16'h0);
        bus.time_data = 16'h0731;
        tick();
        check("ring_on", 16'(bus.buzzer), 16'h1);
        press(4'd5);
        check("ring_key_clear", 16'(bus.buzzer), 16'h0);
        tick();
        check("ring_key_consumed", 16'(bus.entry_mode), 16'h0);
        check("ring_static_quiet", 16'(bus.buzzer), 16'h0);
        tick();
        check("ring_display", bus.display_data, 16'h0731);
        bus.time_data = 16'h0730;
        tick();
        bus.time_data = 16'h0731;
        tick();
        check("ring_again", 16'(bus.buzzer), 16'h1);
        bus.time_data = 16'h0732;
        tick();
        check("ring_minute_end", 16'(bus.buzzer), 16'h0);

        // five digits: oldest shifts out
        press(4'd9);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        commit_time();
        check("wrap_set_data", bus.set_data, 16'h1234);
        check("wrap_load",     16'(bus.load_time), 16'h1);
        tick();

        // timeout after 16 idle cycles
        press(4'd5);
        repeat (15) tick();
        check("to_still_entry", 16'(bus.entry_mode), 16'h1);
        tick();
        check("to_exit",    16'(bus.entry_mode), 16'h0);
        check("to_noerror", 16'(bus.error), 16'h0);
        check("to_noload",  16'(bus.load_time), 16'h0);
        tick();
        check("to_set_kept", bus.set_data, 16'h1234);

        // reset during an entry of three digits
        press(4'd1);
        press(4'd2);
        press(4'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_set_data",   bus.set_data, 16'h0000);
        check("mrst_alarm_data", bus.alarm_data, 16'h0000);
        check("mrst_alarm_en",   16'(bus.alarm_en), 16'h0);
        check("mrst_entry_mode", 16'(bus.entry_mode), 16'h0);
        check("mrst_display",    bus.display_data, 16'h0000);
        check("mrst_load",       16'(bus.load_time), 16'h0);
        tick();
        check("mrst_no_load", 16'(bus.load_time), 16'h0);

        // time_btn and alarm rise together: time wins
        enter4(4'd1, 4'd5, 4'd4, 4'd5);
        bus.time_btn  = 1'b1;
        bus.alarm_btn = 1'b1;
        tick();
        bus.time_btn  = 1'b0;
        bus.alarm_btn = 1'b0;
        check("both_set_data",   bus.set_data, 16'h1545);
        check("both_load",       16'(bus.load_time), 16'h1);
        check("both_alarm_data", bus.alarm_data, 16'h0000);
        check("both_alarm_en",   16'(bus.alarm_en), 16'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Front-panel controller for the alarm clock. It collects BCD digits from the keypad and validates them as HH:MM. It then either loads them into the time counter (drives set_data/load_time) or stores them as the alarm time. It selects what the display shows, compares the running time against the alarm, and drives the buzzer. It sits between keypad/button debouncers and the time counter and display.

Parameters:
TIMEOUT_CYCLES, 16, idle cycles in KEY_ENTRY before the entry is abandoned.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
key_valid  in  1  one-cycle strobe: key_code is valid
key_code  in  4  keypad code; 0-9 are digits, 10-15 are ignored
time_btn  in  1  one-cycle strobe: commit entry as time
alarm_btn  in  1  level: commit entry as alarm (rising edge) / show alarm while held
time_data  in  16  current time from the time counter, BCD HHMM
set_data  out  16  value presented to the time counter
load_time  out  1  load strobe to the time counter
alarm_data  out  16  stored alarm time, BCD HHMM
alarm_en  out  1  alarm armed
display_data  out  16  BCD HHMM to the display
entry_mode  out  1  high in KEY_ENTRY (display blinks)
error  out  1  one-cycle pulse: rejected entry
buzzer  out  1  alarm ringing

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: all state is cleared on a clk edge where rst_n=0. Reset values: state=SHOW_TIME, key_buf=0, digit count=0, set_data=0, load_time=0, alarm_data=0, alarm_en=0, error=0, buzzer=0, timeout counter=0, prev_time=0. Reset mid-entry discards the entry; no load is issued.
- States: SHOW_TIME, KEY_ENTRY, LOAD, SHOW_ALARM. All outputs are registered.
- alarm_btn edge detection: rise = alarm_btn & !alarm_btn_d, where alarm_btn_d is registered.
- SHOW_TIME:
  - display_data=time_data.
  - Digit key: key_buf <= {12'h000, key_code}, digit count=1, go to KEY_ENTRY.
  - alarm_btn high: go to SHOW_ALARM.
  - time_btn: ignored.
- KEY_ENTRY:
  - display_data=key_buf; entry_mode=1.
  - Digit key: key_buf <= {key_buf[11:0], key_code}. After 4 digits, further digits shift the oldest digit out. Each key resets the timeout counter.
  - Commit on time_btn, or on alarm rise; time_btn has priority if both occur in the same cycle.
  - A commit is valid only if the digit count is 4, HH<=23, MM<=59, and every nibble is <=9.
  - Invalid commit: error=1 for one cycle, key_buf cleared, go to SHOW_TIME.
  - Valid time commit: set_data<=key_buf, go to LOAD.
  - Valid alarm commit: alarm_data<=key_buf and alarm_en<=1 on the same edge, go to SHOW_TIME.
  - Timeout: after TIMEOUT_CYCLES consecutive cycles with no key or commit, go to SHOW_TIME silently (no error).
- LOAD:
  - load_time=1 for exactly one cycle; set_data is held stable (it keeps its value after LOAD as well).
  - Next state is SHOW_TIME. One-minute ticks during the load are lost, by design.
- SHOW_ALARM:
  - display_data=alarm_data.
  - Return to SHOW_TIME on the first cycle alarm_btn is low.
  - Digits are ignored in this state.
- Alarm compare:
  - prev_time<=time_data every cycle.
  - Ring condition: alarm_en=1, time_data!=prev_time, and time_data==alarm_data. Then buzzer<=1 on the next edge.
  - Compare is on change only, so loading a time equal to the alarm does ring; a static match after reset does not.
- Buzzer clear: any key_valid, time_btn, or alarm rise clears the buzzer. That event is consumed and has no other effect in that cycle. A subsequent time_data change also clears it (rings at most one minute).
- Simultaneous ring condition and clear event: clear wins.
- alarm_en is never cleared except by reset; re-committing an alarm overwrites alarm_data.

Test Plan:
- Reset then keys 1,2,3,0, time_btn -> set_data=16'h1230; load_time high exactly 1 cycle, 1 cycle after the time_btn edge; display returns to time_data.
- Keys 2,4,0,0, time_btn -> error pulse of 1 cycle, no load_time. Repeat with keys 1,2,6,0 -> error. Repeat with 3 digits 1,2,3 -> error.
- Keys 0,7,3,0, alarm_btn rise -> alarm_data=16'h0730, alarm_en=1. Hold alarm_btn -> display_data=16'h0730. Release -> display_data=time_data.
- Alarm set to 16'h0731; time_data steps 0730->0731 -> buzzer=1 next cycle. key_valid -> buzzer=0, key_buf unchanged, stays in SHOW_TIME.
- Keys 9,1,2,3,4 then time_btn -> set_data=16'h1234 (wrap of oldest digit). Separately: key 5, then TIMEOUT_CYCLES idle cycles -> back to SHOW_TIME with no load and no error.
- rst_n=0 for 1 cycle during KEY_ENTRY with 3 digits entered -> all outputs at reset values next cycle. Same cycle time_btn and alarm rise with valid key_buf -> time load only; alarm_data unchanged.
